// File: rtl/alu_acc_ctrl_if.sv
// Request/response handshake bundle for alu_acc_ctrl.
// Request: in_valid/in_ready carry in_load, in_op, in_data.
// Response: out_valid/out_ready carry out_data, out_ovf.
interface alu_acc_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_load;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid,
        output in_load,
        output in_op,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ovf
    );

    // The sequencer itself.
    modport slave (
        input  in_valid,
        input  in_load,
        input  in_op,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ovf
    );
endinterface

// File: rtl/alu_acc_ctrl.sv
// Accumulator sequencer in front of the 8-bit ALU.
// Ports: clk, rst (async high); bus (slave handshake bundle);
//   alu_a/alu_b/alu_s to the ALU, alu_f/alu_ovf back from it;
//   acc, ovf_sticky, op_count status.
module alu_acc_ctrl (
    input  logic       clk,
    input  logic       rst,
    alu_acc_ctrl_if.slave bus,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_s,
    input  logic [7:0] alu_f,
    input  logic       alu_ovf,
    output logic [7:0] acc,
    output logic       ovf_sticky,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] b_q, b_d;
    logic [1:0] s_q, s_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_ovf_q, out_ovf_d;
    logic       sticky_q, sticky_d;
    logic [7:0] count_q, count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= 8'h00;
            b_q        <= 8'h00;
            s_q        <= 2'b00;
            out_data_q <= 8'h00;
            out_ovf_q  <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            s_q        <= s_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        b_d        = b_q;
        s_d        = s_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        sticky_d   = sticky_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_load) begin
                        // Load bypasses the ALU and restarts
                        // overflow tracking.
                        acc_d      = bus.in_data;
                        out_data_d = bus.in_data;
                        out_ovf_d  = 1'b0;
                        sticky_d   = 1'b0;
                        state_d    = RESP;
                    end else begin
                        b_d     = bus.in_data;
                        s_d     = bus.in_op;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                // ALU inputs have been stable for a full cycle.
                acc_d      = alu_f;
                out_data_d = alu_f;
                out_ovf_d  = alu_ovf;
                sticky_d   = sticky_q | alu_ovf;
                count_d    = count_q + 8'd1;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs depend on state only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == RESP);
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

    assign alu_a      = acc_q;
    assign alu_b      = b_q;
    assign alu_s      = s_q;
    assign acc        = acc_q;
    assign ovf_sticky = sticky_q;
    assign op_count   = count_q;

endmodule
